// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with free-run and counted-burst stepping, zero-seed guard and wrap pulse.
// Optional step/period counter enabled by defining LFSR_PERIOD_CNT_EN.
module lfsr_gen #(
  parameter int unsigned       WIDTH   = 4,
  parameter logic [WIDTH-1:0]  TAPS    = 4'b1100,
  parameter int unsigned       BURST_W = 8
) (
  input  logic               clkslow,
  input  logic               rst,
  input  logic               sel,
  input  logic [WIDTH-1:0]   seed,
  input  logic               run,
  input  logic               burst_go,
  input  logic [BURST_W-1:0] burst_len,
  output logic [WIDTH-1:0]   wint,
  output logic               busy,
  output logic               done,
  output logic               wrap,
  output logic               seed_err,
  output logic [WIDTH-1:0]   period
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_BURST} state_e;

  state_e             state_q;
  logic [BURST_W-1:0] cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   wint_q;
  logic [WIDTH-1:0]   seed_q;
  logic               wrap_q;
  logic               seed_err_q;
  logic [WIDTH-1:0]   wint_d;
  logic               step_d;

  always_comb begin
    wint_d = {wint_q[WIDTH-2:0], ^(wint_q & TAPS)};
  end

  // Step decision for this edge; burst_go outranks run in IDLE, a zero-length burst never steps.
  always_comb begin
    step_d = 1'b0;
    if (!sel) begin
      case (state_q)
        S_IDLE:  step_d = burst_go ? (burst_len != '0) : run;
        S_RUN:   step_d = run;
        S_BURST: step_d = 1'b1;
        default: step_d = 1'b0;
      endcase
    end
  end

  // cnt_q holds the steps still owed after the current one, so the entry step in IDLE
  // counts toward the burst and a length of 1 finishes without leaving IDLE.
  always_ff @(posedge clkslow) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (sel) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (burst_go) begin
              if (burst_len > BURST_W'(1)) begin
                state_q <= S_BURST;
                cnt_q   <= burst_len - 1'b1;
                busy_q  <= 1'b1;
              end else begin
                done_q <= 1'b1;
              end
            end else if (run) begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
            end
          end
          S_RUN: begin
            if (!run) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
          S_BURST: begin
            if (cnt_q == BURST_W'(1)) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clkslow) begin
    if (rst) begin
      wint_q     <= '1;
      seed_q     <= '1;
      wrap_q     <= 1'b0;
      seed_err_q <= 1'b0;
    end else begin
      wrap_q     <= 1'b0;
      seed_err_q <= 1'b0;
      if (sel) begin
        if (seed == '0) begin
          wint_q     <= '1;
          seed_q     <= '1;
          seed_err_q <= 1'b1;
        end else begin
          wint_q <= seed;
          seed_q <= seed;
        end
      end else if (step_d) begin
        wint_q <= wint_d;
        wrap_q <= (wint_d == seed_q);
      end
    end
  end

`ifdef LFSR_PERIOD_CNT_EN
  logic [WIDTH-1:0] pcnt_q;
  logic [WIDTH-1:0] period_q;

  always_ff @(posedge clkslow) begin
    if (rst) begin
      pcnt_q   <= '0;
      period_q <= '0;
    end else if (sel) begin
      pcnt_q <= '0;
    end else if (step_d) begin
      if (wint_d == seed_q) begin
        period_q <= pcnt_q + 1'b1;
        pcnt_q   <= '0;
      end else begin
        if (pcnt_q == '1) period_q <= '1;
        pcnt_q <= pcnt_q + 1'b1;
      end
    end
  end

  assign period = period_q;
`else
  assign period = '0;
`endif

  assign wint     = wint_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign wrap     = wrap_q;
  assign seed_err = seed_err_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed table-driven bench for lfsr_gen at WIDTH=4, TAPS=x^4+x^3+1.
module tb_lfsr_gen;

  logic       clkslow = 1'b0;
  logic       rst = 1'b0;
  logic       sel = 1'b0;
  logic [3:0] seed = '0;
  logic       run = 1'b0;
  logic       burst_go = 1'b0;
  logic [7:0] burst_len = '0;
  logic [3:0] wint;
  logic       busy, done, wrap, seed_err;
  logic [3:0] period;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .BURST_W(8)) dut (
    .clkslow(clkslow), .rst(rst), .sel(sel), .seed(seed), .run(run),
    .burst_go(burst_go), .burst_len(burst_len), .wint(wint), .busy(busy),
    .done(done), .wrap(wrap), .seed_err(seed_err), .period(period)
  );

  always #5 clkslow = ~clkslow;

  typedef struct {
    logic       sel;
    logic [3:0] seed;
    logic       run;
    logic       go;
    logic [7:0] len;
    logic [3:0] w;
    logic       busy;
    logic       done;
    logic       wrap;
    logic       err;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic [3:0] sd, input logic r, input logic g,
                     input logic [7:0] l, input logic [3:0] w, input logic b,
                     input logic d, input logic wr, input logic e);
    vec_t v;
    v.sel = s; v.seed = sd; v.run = r; v.go = g; v.len = l;
    v.w = w; v.busy = b; v.done = d; v.wrap = wr; v.err = e;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic s, input logic [3:0] sd, input logic r,
                       input logic g, input logic [7:0] l);
    sel = s; seed = sd; run = r; burst_go = g; burst_len = l;
    @(posedge clkslow);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] w, input logic b,
                         input logic d, input logic wr, input logic e);
    chk({tag, " wint"}, 32'(wint), 32'(w));
    chk({tag, " busy"}, 32'(busy), 32'(b));
    chk({tag, " done"}, 32'(done), 32'(d));
    chk({tag, " wrap"}, 32'(wrap), 32'(wr));
    chk({tag, " seed_err"}, 32'(seed_err), 32'(e));
`ifndef LFSR_PERIOD_CNT_EN
    chk({tag, " period"}, 32'(period), 32'd0);
`endif
  endtask

  logic [3:0] fr_seq [15];
  logic [3:0] wb_seq [14];

  initial begin
    fr_seq = '{4'b1110, 4'b1100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011,
               4'b0110, 4'b1101, 4'b1010, 4'b0101, 4'b1011, 4'b0111, 4'b1111};
    // sequence from 1101 while the stored seed is 1001 (wrap at step 12)
    wb_seq = '{4'b1010, 4'b0101, 4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100,
               4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110};

    //   sel seed     run go len    wint    busy done wrap err
    add(1, 4'b1111, 0, 0, 8'd0, 4'b1111, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++)
      add(0, 4'b0000, 1, 0, 8'd0, fr_seq[i], 1, 0, (i == 14), 0);
    add(0, 4'b0000, 0, 0, 8'd0, 4'b1111, 0, 0, 0, 0);   // RUN -> IDLE, no step
    add(1, 4'b0000, 0, 0, 8'd0, 4'b1111, 0, 0, 0, 1);   // zero seed
    add(0, 4'b0000, 0, 0, 8'd0, 4'b1111, 0, 0, 0, 0);
    add(0, 4'b0000, 0, 1, 8'd3, 4'b1110, 1, 0, 0, 0);   // burst of 3
    add(0, 4'b0000, 0, 0, 8'd0, 4'b1100, 1, 0, 0, 0);
    add(0, 4'b0000, 0, 0, 8'd0, 4'b1000, 0, 1, 0, 0);
    add(0, 4'b0000, 0, 0, 8'd0, 4'b1000, 0, 0, 0, 0);
    add(0, 4'b0000, 1, 1, 8'd0, 4'b1000, 0, 1, 0, 0);   // zero-length burst
    add(0, 4'b0000, 0, 0, 8'd0, 4'b1000, 0, 0, 0, 0);
    add(0, 4'b0000, 0, 1, 8'd5, 4'b0001, 1, 0, 0, 0);   // burst aborted by load
    add(0, 4'b0000, 0, 0, 8'd0, 4'b0010, 1, 0, 0, 0);
    add(1, 4'b1001, 1, 1, 8'd4, 4'b1001, 0, 0, 0, 0);
    add(0, 4'b0000, 0, 0, 8'd0, 4'b1001, 0, 0, 0, 0);
    add(0, 4'b0000, 1, 1, 8'd2, 4'b0011, 1, 0, 0, 0);   // burst_go beats run
    add(0, 4'b0000, 1, 0, 8'd0, 4'b0110, 0, 1, 0, 0);
    add(0, 4'b0000, 0, 0, 8'd0, 4'b0110, 0, 0, 0, 0);
    add(0, 4'b0000, 0, 1, 8'd1, 4'b1101, 0, 1, 0, 0);   // single-step burst
    add(0, 4'b0000, 0, 0, 8'd0, 4'b1101, 0, 0, 0, 0);

    rst = 1'b1;
    @(posedge clkslow);
    @(posedge clkslow);
    #1;
    chk_out("reset", 4'b1111, 0, 0, 0, 0);
    chk("reset period", 32'(period), 32'd0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].sel, tbl[i].seed, tbl[i].run, tbl[i].go, tbl[i].len);
      chk_out($sformatf("row%0d", i), tbl[i].w, tbl[i].busy, tbl[i].done, tbl[i].wrap, tbl[i].err);
    end

    // 14-step burst from 1101 with stored seed 1001: wrap mid-burst, done on the last step
    drive(0, 4'b0000, 0, 1, 8'd14);
    chk_out("wb0", wb_seq[0], 1, 0, 0, 0);
    for (int i = 1; i < 14; i++) begin
      drive(0, 4'b0000, 0, 0, 8'd0);
      chk_out($sformatf("wb%0d", i), wb_seq[i], (i != 13), (i == 13), (i == 11), 0);
    end

    // reset during RUN from 0110
    drive(0, 4'b0000, 1, 0, 8'd0);
    chk_out("rr0", 4'b1101, 1, 0, 0, 0);
    drive(0, 4'b0000, 1, 0, 8'd0);
    chk_out("rr1", 4'b1010, 1, 0, 0, 0);
    rst = 1'b1;
    drive(0, 4'b0000, 1, 0, 8'd0);
    rst = 1'b0;
    chk_out("rr_rst", 4'b1111, 0, 0, 0, 0);
    drive(0, 4'b0000, 0, 0, 8'd0);
    chk_out("rr_idle", 4'b1111, 0, 0, 0, 0);

    // full period after reset (stored seed back to 1111)
    for (int i = 0; i < 15; i++) begin
      drive(0, 4'b0000, 1, 0, 8'd0);
      chk_out($sformatf("per%0d", i), fr_seq[i], 1, 0, (i == 14), 0);
    end
`ifdef LFSR_PERIOD_CNT_EN
    chk("period on wrap", 32'(period), 32'd15);
`endif
    drive(0, 4'b0000, 0, 0, 8'd0);
    chk_out("end", 4'b1111, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
